// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester Ethernet TX arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_tx_arbiter_pkg;

  // Default frame length limit (bytes forwarded, including the final byte).
  localparam int MAX_FRAME_LEN_DEF = 1522;
  // Default width of the statistics counters.
  localparam int CNT_WIDTH_DEF     = 16;
  // Byte-in-frame counter width; it covers the legal 2..2047 limit range.
  localparam int BYTE_CNT_W        = 11;

  // Arbiter control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no owner, waiting for a request
    ST_PASS = 2'd1,   // owner's beats flow straight through to the MAC
    ST_DROP = 2'd2    // frame was cut; owner's remaining beats are sunk
  } arb_state_t;

  // Requester index: 0 selects s0, 1 selects s1.
  typedef logic owner_t;

  // One-hot grant vector for an owner index.
  function automatic logic [1:0] owner_onehot(input owner_t o);
    return o ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/eth_rr_pick2.sv
// Two-way round-robin selector: picks the requester that did not own last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module eth_rr_pick2
  import eth_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       pick_vld,
  output owner_t     pick
);

  // Under contention alternate away from the last owner; otherwise take whoever asks.
  always_comb begin
    pick_vld = |req;
    pick     = 1'b0;
    if (&req) begin
      pick = ~last_owner;
    end else if (req[1]) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Merges two AXI-Stream frame sources onto one 1G MAC TX stream, frame-atomic, round-robin.
// Latency: one arbitration bubble before each frame, then zero-cycle combinational pass-through.
// Backpressure: owner tready follows m_axis_tready in PASS; non-owner is held off; DROP sinks freely.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                 clock125,
  input  logic                 resetn,

  input  logic [7:0]           s0_axis_tdata,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic                 s0_axis_tlast,
  input  logic                 s0_axis_tuser,

  input  logic [7:0]           s1_axis_tdata,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic                 s1_axis_tlast,
  input  logic                 s1_axis_tuser,

  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,

  output logic [CNT_WIDTH-1:0] frames_sent0,
  output logic [CNT_WIDTH-1:0] frames_sent1,
  output logic [CNT_WIDTH-1:0] frames_truncated,
  output logic [1:0]           grant
);

  // Index of the beat that must carry tlast when a frame reaches the limit.
  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(MAX_FRAME_LEN - 1);

  arb_state_t            state, state_nxt;
  owner_t                owner, last_owner, pick;
  logic                  pick_vld;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  at_limit;

  // Owner-side view of the selected source.
  logic [7:0]            own_tdata;
  logic                  own_tvalid, own_tlast, own_tuser;
  logic                  own_rdy;

  // Control strobes from the next-state logic into the registers.
  logic                  owner_ld, last_ld, cnt_clr, cnt_inc, inc_sent, inc_trunc;

  eth_rr_pick2 u_pick (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_owner (last_owner),
    .pick_vld   (pick_vld),
    .pick       (pick)
  );

  assign own_tdata  = owner ? s1_axis_tdata  : s0_axis_tdata;
  assign own_tvalid = owner ? s1_axis_tvalid : s0_axis_tvalid;
  assign own_tlast  = owner ? s1_axis_tlast  : s0_axis_tlast;
  assign own_tuser  = owner ? s1_axis_tuser  : s0_axis_tuser;
  assign at_limit   = (byte_cnt == LAST_IDX);

  // Next-state, handshake steering and register strobes; tvalid never looks at m_axis_tready.
  always_comb begin
    state_nxt     = state;
    owner_ld      = 1'b0;
    last_ld       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    inc_sent      = 1'b0;
    inc_trunc     = 1'b0;
    own_rdy       = 1'b0;
    grant         = 2'b00;
    m_axis_tdata  = own_tdata;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_ld  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_PASS;
        end
      end

      ST_PASS: begin
        grant         = owner_onehot(owner);
        own_rdy       = m_axis_tready;
        m_axis_tvalid = own_tvalid;
        // At the limit the beat is forced to close the frame and flagged bad,
        // unless the source is ending the frame on that very beat anyway.
        m_axis_tlast  = own_tlast | at_limit;
        m_axis_tuser  = own_tuser | (at_limit & ~own_tlast);
        if (own_tvalid && m_axis_tready) begin
          cnt_inc = 1'b1;
          if (own_tlast) begin
            inc_sent  = 1'b1;
            last_ld   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (at_limit) begin
            inc_sent  = 1'b1;
            inc_trunc = 1'b1;
            state_nxt = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        grant   = owner_onehot(owner);
        own_rdy = 1'b1;
        if (own_tvalid && own_tlast) begin
          last_ld   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign s0_axis_tready = own_rdy & (owner == 1'b0);
  assign s1_axis_tready = own_rdy & (owner == 1'b1);

  // Control registers: state, current owner, fairness history and byte position.
  always_ff @(posedge clock125 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;   // port 0 wins the first contention after reset
      byte_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (owner_ld) begin
        owner <= pick;
      end
      if (last_ld) begin
        last_owner <= owner;
      end
      if (cnt_clr) begin
        byte_cnt <= '0;
      end else if (cnt_inc) begin
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      end
    end
  end

  // Statistics: free-running wrap-around counters; sent and truncated may bump together.
  always_ff @(posedge clock125 or negedge resetn) begin
    if (!resetn) begin
      frames_sent0     <= '0;
      frames_sent1     <= '0;
      frames_truncated <= '0;
    end else begin
      if (inc_sent && (owner == 1'b0)) begin
        frames_sent0 <= frames_sent0 + CNT_WIDTH'(1);
      end
      if (inc_sent && (owner == 1'b1)) begin
        frames_sent1 <= frames_sent1 + CNT_WIDTH'(1);
      end
      if (inc_trunc) begin
        frames_truncated <= frames_truncated + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter.
// Latency: n/a.
// Backpressure: sink tready is fixed or pseudo-random per test.
module tb_eth_tx_arbiter;

  localparam int MAXL = 1522;
  localparam int CW   = 16;

  logic          clock125;
  logic          resetn;
  logic [7:0]    s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [CW-1:0] frames_sent0, frames_sent1, frames_truncated;
  logic [1:0]    grant;

  int n_cmp  = 0;
  int n_fail = 0;
  int timeouts = 0;
  int viol = 0;
  int cyc = 0;
  bit rnd_en = 0;
  bit rdy_fix = 0;

  logic [7:0] mon_dat[$];
  bit         mon_last[$];
  bit         mon_user[$];
  logic [1:0] mon_grant[$];
  int         mon_cyc[$];
  logic [7:0] exp_dat[$];
  bit         exp_last[$];
  bit         exp_user[$];

  eth_tx_arbiter #(.MAX_FRAME_LEN(MAXL), .CNT_WIDTH(CW)) dut (
    .clock125         (clock125),
    .resetn           (resetn),
    .s0_axis_tdata    (s0_axis_tdata),
    .s0_axis_tvalid   (s0_axis_tvalid),
    .s0_axis_tready   (s0_axis_tready),
    .s0_axis_tlast    (s0_axis_tlast),
    .s0_axis_tuser    (s0_axis_tuser),
    .s1_axis_tdata    (s1_axis_tdata),
    .s1_axis_tvalid   (s1_axis_tvalid),
    .s1_axis_tready   (s1_axis_tready),
    .s1_axis_tlast    (s1_axis_tlast),
    .s1_axis_tuser    (s1_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frames_sent0     (frames_sent0),
    .frames_sent1     (frames_sent1),
    .frames_truncated (frames_truncated),
    .grant            (grant)
  );

  // 125 MHz clock.
  initial begin
    clock125 = 1'b0;
    forever #4 clock125 = ~clock125;
  end

  // Cycle index used to measure gaps between frames.
  always @(posedge clock125) cyc <= cyc + 1;

  // Sink ready: fixed level or a fresh coin flip each cycle.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clock125);
      #1;
      m_axis_tready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Output-side monitor and non-owner ready watchdog, sampled mid-cycle.
  always @(negedge clock125) begin
    if (resetn && m_axis_tvalid && m_axis_tready) begin
      mon_dat.push_back(m_axis_tdata);
      mon_last.push_back(m_axis_tlast);
      mon_user.push_back(m_axis_tuser);
      mon_grant.push_back(grant);
      mon_cyc.push_back(cyc);
    end
    if (resetn) begin
      if (grant != 2'b01 && s0_axis_tready) viol++;
      if (grant != 2'b10 && s1_axis_tready) viol++;
    end
  end

  function automatic logic [7:0] dat_of(input int port, input int f, input int i);
    return 8'(port * 128 + f * 37 + i);
  endfunction

  // Index of the first beat where monitor and expectation disagree, -1 if identical.
  function automatic int first_diff();
    int n;
    n = (mon_dat.size() < exp_dat.size()) ? mon_dat.size() : exp_dat.size();
    for (int i = 0; i < n; i++) begin
      if (mon_dat[i] !== exp_dat[i] || mon_last[i] !== exp_last[i] || mon_user[i] !== exp_user[i])
        return i;
    end
    if (mon_dat.size() != exp_dat.size()) return n;
    return -1;
  endfunction

  task automatic clear_q();
    mon_dat.delete(); mon_last.delete(); mon_user.delete(); mon_grant.delete(); mon_cyc.delete();
    exp_dat.delete(); exp_last.delete(); exp_user.delete();
    viol = 0;
  endtask

  // Expected output image of one source frame, including truncation.
  task automatic add_exp(input int port, input int f, input int len, input bit user_last);
    int n;
    n = (len > MAXL) ? MAXL : len;
    for (int i = 0; i < n; i++) begin
      exp_dat.push_back(dat_of(port, f, i));
      exp_last.push_back(i == n - 1);
      exp_user.push_back((i == len - 1 && user_last) || (len > MAXL && i == n - 1));
    end
  endtask

  task automatic set_src(input int port, input bit v, input logic [7:0] d, input bit l, input bit u);
    if (port == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l; s0_axis_tuser = u;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l; s1_axis_tuser = u;
    end
  endtask

  // Present one frame beat by beat; each beat waits a bounded time for its handshake.
  task automatic send_frame(input int port, input int f, input int len, input bit user_last,
                            input bit gaps, input bit no_last);
    int  t;
    bit  rdy;
    bit  lst;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        set_src(port, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clock125);
        #1;
      end
      lst = (i == len - 1) && !no_last;
      set_src(port, 1'b1, dat_of(port, f, i), lst, lst && user_last);
      t = 0;
      forever begin
        @(negedge clock125);
        rdy = (port == 0) ? s0_axis_tready : s1_axis_tready;
        @(posedge clock125);
        #1;
        if (rdy) break;
        t++;
        if (t > 5000) begin
          timeouts++;
          set_src(port, 1'b0, 8'h00, 1'b0, 1'b0);
          return;
        end
      end
    end
    set_src(port, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clock125);
    #1;
    resetn = 1'b1;
    @(posedge clock125);
    #1;
    clear_q();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_src(0, 1'b1, 8'h11, 1'b0, 1'b0);
    set_src(1, 1'b1, 8'h22, 1'b0, 1'b0);
    rdy_fix = 1'b1;
    repeat (3) @(posedge clock125);
    #2;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid got %b want 0", m_axis_tvalid); end
    n_cmp++; if ({s1_axis_tready, s0_axis_tready} !== 2'b00) begin n_fail++; $display("FAIL rst_tready got %b want 00", {s1_axis_tready, s0_axis_tready}); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got %b want 00", grant); end
    n_cmp++; if ({frames_sent0, frames_sent1, frames_truncated} !== '0) begin n_fail++; $display("FAIL rst_stats got %0d/%0d/%0d want 0/0/0", frames_sent0, frames_sent1, frames_truncated); end
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b1;
    repeat (2) @(posedge clock125);
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant got %b want 00", grant); end
  endtask

  task automatic test_single_frame();
    int d, bad_g, t0;
    do_reset();
    t0 = timeouts;
    rdy_fix = 1'b1;
    add_exp(0, 0, 60, 1'b0);
    send_frame(0, 0, 60, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL single_seq beats=%0d first_bad=%0d want 60 beats identical", mon_dat.size(), d); end
    bad_g = 0;
    foreach (mon_grant[i]) if (mon_grant[i] !== 2'b01) bad_g++;
    n_cmp++; if (bad_g !== 0) begin n_fail++; $display("FAIL single_grant beats_not_01=%0d want 0", bad_g); end
    n_cmp++; if (frames_sent0 !== CW'(1)) begin n_fail++; $display("FAIL single_sent0 got %0d want 1", frames_sent0); end
    n_cmp++; if (frames_sent1 !== CW'(0)) begin n_fail++; $display("FAIL single_sent1 got %0d want 0", frames_sent1); end
    n_cmp++; if (timeouts - t0 !== 0) begin n_fail++; $display("FAIL single_timeout got %0d want 0", timeouts - t0); end
  endtask

  task automatic test_round_robin();
    int d, bad_gap, t0;
    do_reset();
    t0 = timeouts;
    rdy_fix = 1'b1;
    for (int f = 0; f < 3; f++) begin
      add_exp(0, f, 64, 1'b0);
      add_exp(1, f, 64, 1'b0);
    end
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(0, f, 64, 1'b0, 1'b0, 1'b0);
      end
      begin
        for (int f = 0; f < 3; f++) send_frame(1, f, 64, 1'b0, 1'b0, 1'b0);
      end
    join
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL rr_order beats=%0d first_bad=%0d want 384 beats 0,1,0,1,0,1", mon_dat.size(), d); end
    bad_gap = 0;
    if (mon_cyc.size() == 384) begin
      for (int k = 1; k < 6; k++) if (mon_cyc[k * 64] - mon_cyc[k * 64 - 1] != 2) bad_gap++;
    end else begin
      bad_gap = -1;
    end
    n_cmp++; if (bad_gap !== 0) begin n_fail++; $display("FAIL rr_gap bad_boundaries=%0d want 0", bad_gap); end
    n_cmp++; if ({frames_sent0, frames_sent1} !== {CW'(3), CW'(3)}) begin n_fail++; $display("FAIL rr_sent got %0d/%0d want 3/3", frames_sent0, frames_sent1); end
    n_cmp++; if (timeouts - t0 !== 0) begin n_fail++; $display("FAIL rr_timeout got %0d want 0", timeouts - t0); end
  endtask

  task automatic test_truncation();
    int d, t0;
    do_reset();
    t0 = timeouts;
    rdy_fix = 1'b1;
    add_exp(1, 2, 2000, 1'b0);
    send_frame(1, 2, 2000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL trunc_seq beats=%0d first_bad=%0d want 1522 with tlast+tuser on last", mon_dat.size(), d); end
    n_cmp++; if (frames_truncated !== CW'(1)) begin n_fail++; $display("FAIL trunc_cnt got %0d want 1", frames_truncated); end
    n_cmp++; if (frames_sent1 !== CW'(1)) begin n_fail++; $display("FAIL trunc_sent1 got %0d want 1", frames_sent1); end
    n_cmp++; if (timeouts - t0 !== 0) begin n_fail++; $display("FAIL trunc_drop_accept timeouts=%0d want 0", timeouts - t0); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL trunc_idle_grant got %b want 00", grant); end
  endtask

  task automatic test_exact_max();
    int d;
    clear_q();
    rdy_fix = 1'b1;
    add_exp(0, 3, MAXL, 1'b0);
    send_frame(0, 3, MAXL, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL exact_seq beats=%0d first_bad=%0d want 1522 clean", mon_dat.size(), d); end
    n_cmp++; if (frames_truncated !== CW'(1)) begin n_fail++; $display("FAIL exact_trunc got %0d want 1", frames_truncated); end
    n_cmp++; if (frames_sent0 !== CW'(1)) begin n_fail++; $display("FAIL exact_sent0 got %0d want 1", frames_sent0); end
  endtask

  task automatic test_random_backpressure();
    int d, t0;
    clear_q();
    t0 = timeouts;
    rnd_en = 1'b1;
    add_exp(0, 5, 100, 1'b0);
    add_exp(1, 6, 10, 1'b0);
    fork
      send_frame(0, 5, 100, 1'b0, 1'b1, 1'b0);
      begin
        repeat (3) @(posedge clock125);
        #1;
        send_frame(1, 6, 10, 1'b0, 1'b1, 1'b0);
      end
    join
    rnd_en = 1'b0;
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL rand_seq beats=%0d first_bad=%0d want 110 identical", mon_dat.size(), d); end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL rand_nonowner_rdy got %0d want 0", viol); end
    n_cmp++; if (timeouts - t0 !== 0) begin n_fail++; $display("FAIL rand_timeout got %0d want 0", timeouts - t0); end
  endtask

  task automatic test_reset_midframe();
    int d, nlast;
    clear_q();
    rdy_fix = 1'b1;
    send_frame(0, 7, 4, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8, 30, 1'b0, 1'b0, 1'b1);
    set_src(0, 1'b1, dat_of(0, 8, 30), 1'b0, 1'b0);
    #1;
    n_cmp++; if ({m_axis_tvalid, grant} !== 3'b101) begin n_fail++; $display("FAIL mid_before got vld=%b grant=%b want 1/01", m_axis_tvalid, grant); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b want 0", m_axis_tvalid); end
    n_cmp++; if ({s1_axis_tready, s0_axis_tready, grant} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rdy_grant got %b want 0000", {s1_axis_tready, s0_axis_tready, grant}); end
    n_cmp++; if (frames_sent0 !== CW'(0)) begin n_fail++; $display("FAIL mid_rst_sent0 got %0d want 0", frames_sent0); end
    nlast = 0;
    foreach (mon_last[i]) if (mon_last[i]) nlast++;
    n_cmp++; if (nlast !== 1 || mon_dat.size() !== 34) begin n_fail++; $display("FAIL mid_no_tlast got beats=%0d lasts=%0d want 34/1", mon_dat.size(), nlast); end
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    resetn = 1'b1;
    @(posedge clock125);
    #1;
    clear_q();
    add_exp(0, 9, 2, 1'b0);
    add_exp(1, 9, 2, 1'b0);
    fork
      send_frame(0, 9, 2, 1'b0, 1'b0, 1'b0);
      send_frame(1, 9, 2, 1'b0, 1'b0, 1'b0);
    join
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL mid_port0_first beats=%0d first_bad=%0d want port0 then port1", mon_dat.size(), d); end
  endtask

  task automatic test_one_byte();
    int d;
    clear_q();
    rdy_fix = 1'b1;
    add_exp(0, 10, 1, 1'b1);
    send_frame(0, 10, 1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clock125);
    #1;
    d = first_diff();
    n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL one_byte beats=%0d first_bad=%0d want 1 beat tlast=1 tuser=1", mon_dat.size(), d); end
    n_cmp++; if (frames_truncated !== CW'(0)) begin n_fail++; $display("FAIL one_byte_trunc got %0d want 0", frames_truncated); end
    n_cmp++; if (frames_sent0 !== CW'(2)) begin n_fail++; $display("FAIL one_byte_sent0 got %0d want 2", frames_sent0); end
  endtask

  initial begin
    resetn = 1'b0;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_single_frame();
    test_round_robin();
    test_truncation();
    test_exact_max();
    test_random_backpressure();
    test_reset_midframe();
    test_one_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 1522, maximum bytes forwarded per frame (including the final byte); legal range 2..2047.
REQ-002 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-003 clock125  input  1  single clock, 125 MHz; all logic is synchronous to it.
REQ-004 resetn  input  1  reset: asynchronous assert, active-low.
REQ-005 s0_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 0 frame stream.
REQ-006 s1_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 1 frame stream.
REQ-007 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  merged stream to the 1G MAC TX_AXIS port.
REQ-008 frames_sent0, frames_sent1  output  CNT_WIDTH  frames completed per requester, including truncated frames.
REQ-009 frames_truncated  output  CNT_WIDTH  frames cut at MAX_FRAME_LEN, both requesters combined.
REQ-010 grant  output  2  one-hot current owner; 00 when idle.

Function
REQ-011 States: IDLE, PASS and DROP; encoding is free.
REQ-012 IDLE behaviour:
  - m_axis_tvalid=0, s0/s1 tready=0, grant=00.
  - If any sN_axis_tvalid=1, the block SHALL latch an owner and enter PASS on the next edge (one bubble cycle).
REQ-013 Round-robin owner selection: if both requesters are valid, the owner SHALL be the port other than last_owner; otherwise the single valid port is selected.
REQ-014 PASS behaviour:
  - m_axis_tdata/tvalid/tlast come combinationally from the owner.
  - m_axis_tuser = owner tuser.
  - owner tready = m_axis_tready; the non-owner tready = 0.
REQ-015 An 11-bit byte counter SHALL reset to 0 on PASS entry and increment on each m_axis handshake.
REQ-016 A PASS handshake with owner tlast=1 SHALL:
  - increment frames_sentN of the owner;
  - set last_owner to the owner;
  - return the block to IDLE.
REQ-017 Truncation: when a PASS handshake occurs with counter = MAX_FRAME_LEN-1 and owner tlast=0, the block SHALL:
  - drive m_axis_tlast=1 and m_axis_tuser=1 on that beat (combinationally);
  - increment frames_sentN of the owner and frames_truncated;
  - enter DROP.
REQ-018 DROP behaviour:
  - m_axis_tvalid=0; owner tready=1; non-owner tready=0.
  - Incoming beats are discarded.
  - The handshake with owner tlast=1 SHALL set last_owner and return the block to IDLE.
REQ-019 A requester deasserting tvalid mid-frame SHALL NOT release the grant; the block waits in PASS without a timeout.
REQ-020 A 1-byte frame (tlast on the first beat) SHALL be forwarded intact; truncation never applies when tlast=1.
REQ-021 Counters SHALL wrap modulo 2^CNT_WIDTH. If the same-cycle increments of frames_sent and frames_truncated coincide, both SHALL update.
REQ-022 m_axis_tvalid SHALL never be combinationally dependent on m_axis_tready.

Reset
REQ-023 While resetn=0, the block SHALL hold:
  - state=IDLE, last_owner=1 (port 0 wins first contention);
  - counter=0, all statistics=0;
  - all tready and m_axis_tvalid=0, grant=00.
REQ-024 Reset asserted mid-frame SHALL abort immediately with no tlast emitted. Downstream MAC/FIFO reset is the integrator's responsibility.

Structure
REQ-025 The shared package SHALL hold:
  - the state enumeration;
  - MAX_FRAME_LEN default and counter width constants;
  - the owner index type.
REQ-026 One sub-module is natural: eth_rr_pick2, a combinational two-way round-robin selector. Everything else stays in eth_tx_arbiter.

Verification
REQ-027 Port 0 sends a 60-byte frame, port 1 idle, m_axis_tready=1 -> 60 beats out, tlast on beat 60, grant=01, frames_sent0=1.
REQ-028 Both ports assert valid in the same cycle after reset, each sending 3 frames of 64 bytes -> output order 0,1,0,1,0,1 with no interleaving inside a frame; one idle cycle between frames.
REQ-029 Port 1 sends 2000 bytes with MAX_FRAME_LEN=1522 -> 1522 bytes out, beat 1522 has tlast=1 and tuser=1; the remaining 478 bytes are accepted and dropped; frames_truncated=1.
REQ-030 Random m_axis_tready (50%) and source tvalid gaps on a 100-byte frame -> the byte sequence is identical to the input and the non-owner tready stays 0 throughout.
REQ-031 resetn pulsed low at byte 30 of a frame -> outputs go to their reset values asynchronously; after release, a new port 0 frame is granted first.
REQ-032 A 1-byte frame with tuser=1 on port 0 -> one beat out with tlast=1 and tuser=1; frames_truncated remains 0.
